// File: rtl/hamming74_decoder.sv
// hamming74_decoder
//   Two-stage pipelined Hamming(7,4) single-error-correcting decoder with
//   valid/ready streaming on both sides and saturating statistics counters.
//
//   Code word bit p (1..7) is cw[p-1]:
//     cw = {d3, d2, d1, p4, d0, p2, p1}, even parity.
//   Stage 1 registers the code word and its syndrome.
//   Stage 2 registers corrected data, the error flag and the syndrome.
//   A word accepted on edge N appears on out_valid after edge N+1.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_cw is the 7-bit code word
//   out_valid/out_ready output handshake
//   out_data            corrected data {d3,d2,d1,d0}
//   out_err             1 = a single-bit error was corrected
//   out_syn             syndrome {s4,s2,s1}; nonzero value = flipped bit position
//   clr_cnt             synchronous clear of both counters, wins over increments
//   word_cnt, err_cnt   saturating counts of delivered words / corrected words
module hamming74_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_cw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             out_err,
    output logic [2:0]       out_syn,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage valids as a small shift register: vld_pipe[1] = S1, vld_pipe[2] = S2.
    logic [2:1]       vld_pipe_q, vld_pipe_d;
    logic [6:0]       s1_cw_q, s1_cw_d;
    logic [2:0]       s1_syn_q, s1_syn_d;
    logic [3:0]       data_q, data_d;
    logic             err_q, err_d;
    logic [2:0]       syn_q, syn_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             s1_rdy, s2_rdy, out_hs;
    logic [2:0]       in_syn;
    logic [6:0]       flip, corr;

    // Ready chain: a stage can load when it is empty or its content moves on.
    always_comb begin
        s2_rdy   = !vld_pipe_q[2] || out_ready;
        s1_rdy   = !vld_pipe_q[1] || s2_rdy;
        in_ready = s1_rdy;
        out_hs   = vld_pipe_q[2] && out_ready;
    end

    // Syndrome of the incoming word, {s4,s2,s1}.
    always_comb begin
        in_syn[0] = in_cw[0] ^ in_cw[2] ^ in_cw[4] ^ in_cw[6];
        in_syn[1] = in_cw[1] ^ in_cw[2] ^ in_cw[5] ^ in_cw[6];
        in_syn[2] = in_cw[3] ^ in_cw[4] ^ in_cw[5] ^ in_cw[6];
    end

    // The syndrome is the position of the flipped bit; invert cw[syn-1].
    // A parity-bit position leaves the data bits untouched.
    always_comb begin
        flip = '0;
        if (s1_syn_q != 3'd0) flip = 7'b1 << (s1_syn_q - 3'd1);
        corr = s1_cw_q ^ flip;
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        s1_cw_d    = s1_cw_q;
        s1_syn_d   = s1_syn_q;
        data_d     = data_q;
        err_d      = err_q;
        syn_d      = syn_q;

        if (s1_rdy) begin
            vld_pipe_d[1] = in_valid;
            if (in_valid) begin
                s1_cw_d  = in_cw;
                s1_syn_d = in_syn;
            end
        end

        if (s2_rdy) begin
            vld_pipe_d[2] = vld_pipe_q[1];
            if (vld_pipe_q[1]) begin
                data_d = {corr[6], corr[5], corr[4], corr[2]};
                err_d  = (s1_syn_q != 3'd0);
                syn_d  = s1_syn_q;
            end
        end
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (clr_cnt) begin
            word_cnt_d = '0;
            err_cnt_d  = '0;
        end else if (out_hs) begin
            if (word_cnt_q != CNT_MAX) word_cnt_d = word_cnt_q + 1'b1;
            if (err_q && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_cw_q    <= '0;
            s1_syn_q   <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            syn_q      <= '0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            s1_cw_q    <= s1_cw_d;
            s1_syn_q   <= s1_syn_d;
            data_q     <= data_d;
            err_q      <= err_d;
            syn_q      <= syn_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = vld_pipe_q[2];
    assign out_data  = data_q;
    assign out_err   = err_q;
    assign out_syn   = syn_q;
    assign word_cnt  = word_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_hamming74_decoder.sv
// Bench for hamming74_decoder: directed vector table, streamed exhaustive
// check with random backpressure, hold/release, counter saturation with a
// narrow-counter instance, clear-vs-increment and mid-stream reset.
module tb_hamming74_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [6:0]  in_cw = 7'h0;

    logic        in_ready, out_valid, out_err;
    logic [3:0]  out_data;
    logic [2:0]  out_syn;
    logic [15:0] word_cnt, err_cnt;

    logic        b_in_ready, b_out_valid, b_out_err;
    logic [3:0]  b_out_data;
    logic [2:0]  b_out_syn;
    logic [1:0]  b_word_cnt, b_err_cnt;

    always #5 clk = ~clk;

    hamming74_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_cw(in_cw), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .out_syn(out_syn),
        .clr_cnt(clr_cnt), .word_cnt(word_cnt), .err_cnt(err_cnt)
    );

    // Narrow-counter copy driven by the same stimulus, used for saturation.
    hamming74_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_cw(in_cw), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_err(b_out_err), .out_syn(b_out_syn),
        .clr_cnt(clr_cnt), .word_cnt(b_word_cnt), .err_cnt(b_err_cnt)
    );

    typedef struct {
        logic [6:0] cw;
        logic [3:0] data;
        logic       err;
        logic [2:0] syn;
    } vec_t;

    typedef struct packed {
        logic [3:0] data;
        logic       err;
        logic [2:0] syn;
    } exp_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [6:0] sw[$];
    exp_t       se[$];
    exp_t       exp_q[$];
    vec_t       tbl[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    // Streams sw[] into the DUT, scoreboarding against se[].
    // mode 0: random out_ready; 1: out_ready low for 5 cycles then high; 2: always high.
    task automatic run_stream(input int mode, input int max_cyc);
        int   idx;
        int   got;
        int   c;
        exp_t e;
        idx = 0;
        got = 0;
        c   = 0;
        exp_q.delete();
        while ((idx < sw.size() || got < sw.size()) && c < max_cyc) begin
            tick();
            case (mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = (c >= 5);
                default: out_ready = 1'b1;
            endcase
            in_valid = (idx < sw.size());
            in_cw    = in_valid ? sw[idx] : 7'h0;
            @(negedge clk);
            if (mode == 1 && c >= 2 && c <= 4) begin
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_held_count", 32'(idx), 32'd2);
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_out_stable", {out_data, out_err, out_syn}, 32'(se[0]));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(se[idx]);
                idx++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra_word", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_word", {out_data, out_err, out_syn}, 32'(e));
                end
                got++;
            end
            c++;
        end
        check("stream_delivered", 32'(got), 32'(sw.size()));
        tick();
        in_valid = 1'b0;
        in_cw    = 7'h0;
    endtask

    initial begin
        exp_t e;
        tbl = '{
            '{7'h66, 4'b1101, 1'b0, 3'd0},
            '{7'h76, 4'b1101, 1'b1, 3'd5},
            '{7'h67, 4'b1101, 1'b1, 3'd1},
            '{7'h00, 4'b0000, 1'b0, 3'd0},
            '{7'h7F, 4'b1111, 1'b0, 3'd0},
            '{7'h7E, 4'b1111, 1'b1, 3'd1},
            '{7'h3F, 4'b1111, 1'b1, 3'd7},
            '{7'h04, 4'b0000, 1'b1, 3'd3},
            '{7'h07, 4'b0001, 1'b0, 3'd0},
            '{7'h47, 4'b0001, 1'b1, 3'd7},
            '{7'h65, 4'b1100, 1'b1, 3'd3}   // double error: miscorrected
        };

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs", {out_data, out_err, out_syn}, 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed table, one word at a time, with latency check
        for (int i = 0; i < 11; i++) begin
            tick();
            in_valid  = 1'b1;
            in_cw     = tbl[i].cw;
            out_ready = 1'b1;
            @(negedge clk);
            check("tbl_in_ready", 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            @(negedge clk);
            check("tbl_not_early", 32'(out_valid), 32'd0);
            tick();
            @(negedge clk);
            check("tbl_out_valid", 32'(out_valid), 32'd1);
            check("tbl_word", {out_data, out_err, out_syn},
                  {24'd0, tbl[i].data, tbl[i].err, tbl[i].syn});
        end
        tick();
        @(negedge clk);
        check("tbl_word_cnt", 32'(word_cnt), 32'd11);
        check("tbl_err_cnt", 32'(err_cnt), 32'd7);

        // Exhaustive: 16 data values x (no flip + 7 single flips), random out_ready
        pulse_clr();
        sw.delete();
        se.delete();
        for (int d = 0; d < 16; d++) begin
            for (int f = 0; f < 8; f++) begin
                logic [6:0] m;
                m = (f == 0) ? 7'h0 : (7'h1 << (f - 1));
                sw.push_back(enc(4'(d)) ^ m);
                e.data = 4'(d);
                e.err  = (f != 0);
                e.syn  = 3'(f);
                se.push_back(e);
            end
        end
        run_stream(0, 3000);
        @(negedge clk);
        check("exh_word_cnt", 32'(word_cnt), 32'd128);
        check("exh_err_cnt", 32'(err_cnt), 32'd112);

        // Backpressure: three words offered while out_ready is low
        sw.delete();
        se.delete();
        sw.push_back(enc(4'd3));
        se.push_back({4'd3, 1'b0, 3'd0});
        sw.push_back(enc(4'd9) ^ 7'h10);
        se.push_back({4'd9, 1'b1, 3'd5});
        sw.push_back(enc(4'd12) ^ 7'h02);
        se.push_back({4'd12, 1'b1, 3'd2});
        run_stream(1, 100);

        // Saturation: 5 errored words into the 2-bit counters
        pulse_clr();
        sw.delete();
        se.delete();
        for (int i = 0; i < 5; i++) begin
            sw.push_back(enc(4'(i + 2)) ^ (7'h1 << i));
            e.data = 4'(i + 2);
            e.err  = 1'b1;
            e.syn  = 3'(i + 1);
            se.push_back(e);
        end
        run_stream(2, 100);
        @(negedge clk);
        check("sat_err_cnt_w2", 32'(b_err_cnt), 32'd3);
        check("sat_word_cnt_w2", 32'(b_word_cnt), 32'd3);
        check("sat_err_cnt_w16", 32'(err_cnt), 32'd5);

        // Clear in the same cycle as an output handshake
        tick();
        in_valid  = 1'b1;
        in_cw     = 7'h76;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        clr_cnt = 1'b1;
        @(negedge clk);
        check("clr_hs_valid", 32'(out_valid), 32'd1);
        tick();
        clr_cnt = 1'b0;
        @(negedge clk);
        check("clr_word_cnt", 32'(word_cnt), 32'd0);
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        check("clr_cnt_w2", {b_word_cnt, b_err_cnt}, 32'd0);
        check("clr_consumed", 32'(out_valid), 32'd0);

        // Reset mid-stream
        tick();
        in_valid  = 1'b1;
        in_cw     = 7'h66;
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("pre_rst_busy", 32'(out_valid && word_cnt != 16'd0), 32'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_cnts", {word_cnt, err_cnt}, 32'd0);
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
